// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter: register address width, x0 and the
// write-port source select.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    SrcNone,
    SrcAlu,
    SrcLdFifo,
    SrcLdBypass
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the arbiter's ALU, load, decode-check and register-file write signals.
// The slave modport is the arbiter side. The master modport is the pipeline side.
interface wb_arbiter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) ();

  logic                     alu_valid;
  logic [4:0]               alu_rd;
  logic [XLEN-1:0]          alu_data;
  logic                     ld_issue;
  logic [4:0]               ld_issue_rd;
  logic                     ld_valid;
  logic [4:0]               ld_rd;
  logic [XLEN-1:0]          ld_data;
  logic                     ld_ready;
  logic [4:0]               chk_rs1;
  logic [4:0]               chk_rs2;
  logic [4:0]               chk_rd;
  logic                     stall;
  logic [$clog2(DEPTH):0]   ld_count;
  logic [4:0]               A3;
  logic [XLEN-1:0]          WD3;
  logic                     WE3;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
           chk_rs1, chk_rs2, chk_rd,
    output ld_ready, stall, ld_count, A3, WD3, WE3
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
           chk_rs1, chk_rs2, chk_rd,
    input  ld_ready, stall, ld_count, A3, WD3, WE3
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO. Pointers wrap modulo Depth, so Depth must be a power of 2.
// A push when full or a pop when empty is ignored.
module wb_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (count_q == CntW'(Depth));
    empty_o  = (count_q == '0);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the occupancy count decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Sole driver of the register-file write port. It merges ALU results with buffered or
// bypassed load responses, and it tracks outstanding loads so that decode can stall on them.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int unsigned EntW = XLEN + REG_ADDR_W;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [EntW-1:0]       fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CntW-1:0]       fifo_count;
  logic                  ld_ready, alu_ok, ld_ok;
  wb_src_e               src;

  logic                  we3_q, we3_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [XLEN-1:0]       wd3_q, wd3_d;
  logic                  is_ld_q, is_ld_d;
  logic [31:0]           pending_q, pending_d;

  wb_fifo #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i ({bus.ld_rd, bus.ld_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // x0 results are dropped before arbitration, so they never take the port or a FIFO slot.
  always_comb begin
    ld_ready  = !fifo_full;
    alu_ok    = bus.alu_valid && (bus.alu_rd != X0);
    ld_ok     = bus.ld_valid && ld_ready && (bus.ld_rd != X0);
    if (alu_ok) begin
      src = SrcAlu;
    end else if (!fifo_empty) begin
      src = SrcLdFifo;
    end else if (ld_ok) begin
      src = SrcLdBypass;
    end else begin
      src = SrcNone;
    end
    fifo_push = ld_ok && (src != SrcLdBypass);
    fifo_pop  = (src == SrcLdFifo);
  end

  always_comb begin
    we3_d   = 1'b0;
    is_ld_d = 1'b0;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    unique case (src)
      SrcAlu: begin
        we3_d = 1'b1;
        a3_d  = bus.alu_rd;
        wd3_d = bus.alu_data;
      end
      SrcLdFifo: begin
        we3_d         = 1'b1;
        is_ld_d       = 1'b1;
        {a3_d, wd3_d} = fifo_rdata;
      end
      SrcLdBypass: begin
        we3_d   = 1'b1;
        is_ld_d = 1'b1;
        a3_d    = bus.ld_rd;
        wd3_d   = bus.ld_data;
      end
      default: ;
    endcase
  end

  // The clear lands once the register file has committed the load. A same-cycle
  // re-issue to that register is applied after the clear, so the set wins.
  always_comb begin
    pending_d = pending_q;
    if (we3_q && is_ld_q) pending_d[a3_q] = 1'b0;
    if (bus.ld_issue && (bus.ld_issue_rd != X0)) pending_d[bus.ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3_q     <= 1'b0;
      is_ld_q   <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      pending_q <= '0;
    end else begin
      we3_q     <= we3_d;
      is_ld_q   <= is_ld_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      pending_q <= pending_d;
    end
  end

  assign bus.stall = ((bus.chk_rs1 != X0) && pending_q[bus.chk_rs1]) ||
                     ((bus.chk_rs2 != X0) && pending_q[bus.chk_rs2]) ||
                     ((bus.chk_rd  != X0) && pending_q[bus.chk_rd]);

  assign bus.ld_ready = ld_ready;
  assign bus.ld_count = fifo_count;
  assign bus.A3       = a3_q;
  assign bus.WD3      = wd3_q;
  assign bus.WE3      = we3_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter sitting directly upstream of the register file; it is the only driver of the file's A3/WD3/WE3 write port.
- Merges single-cycle ALU results with late-arriving load responses.
- Buffers load responses in a DEPTH-entry FIFO while the ALU holds the port.
- Keeps a per-register pending scoreboard so decode stalls on operands whose load has not yet been written.

Parameters:
XLEN, 32, data width of results and WD3
DEPTH, 4, load-response FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
ld_issue_rd  in  5  destination of issued load
ld_valid  in  1  load response present
ld_rd  in  5  load response destination
ld_data  in  XLEN  load response data
ld_ready  out  1  FIFO can accept a response (count < DEPTH)
chk_rs1  in  5  decode source 1
chk_rs2  in  5  decode source 2
chk_rd  in  5  decode destination
stall  out  1  a checked register is pending
ld_count  out  $clog2(DEPTH)+1  FIFO occupancy
A3  out  5  register-file write address
WD3  out  XLEN  register-file write data
WE3  out  1  register-file write enable

Behaviour:
- Reset: WE3=0, A3=0, WD3=0, FIFO emptied (ld_count=0), ld_ready=1, all pending bits 0. Reset mid-operation discards buffered responses and pending bits. rst overrides all same-cycle inputs.
- A3/WD3/WE3 are registered. There is one cycle of latency from an accepted result to WE3 high. The register file commits at the end of the WE3 cycle.
- Port selection each cycle, in priority order:
  - (1) alu_valid with alu_rd!=0 -> ALU result.
  - (2) else FIFO non-empty -> pop head.
  - (3) else ld_valid with ld_rd!=0 and FIFO empty -> bypass the response straight to the port without pushing it.
  - (4) else WE3=0 next cycle; A3/WD3 hold their previous values.
- A load response is pushed when ld_valid && ld_ready && ld_rd!=0 and it was not bypassed. A response with ld_valid while ld_ready=0 is a protocol violation; it is ignored and ld_count is unchanged.
- Push and pop in the same cycle: ld_count is unchanged. The FIFO stays in-order; pointers wrap modulo DEPTH.
- rd==0: ALU or load results targeting x0 are discarded. They never assert WE3 and never consume the write slot or a FIFO entry. ld_issue with rd==0 sets nothing.
- The internal wb_is_ld flag is registered alongside WE3.
- Scoreboard:
  - pending[ld_issue_rd] is set on ld_issue.
  - pending[A3] is cleared at the edge ending a cycle where WE3 && wb_is_ld. Stall therefore drops in the first cycle after the register file holds the data.
  - If a set and a clear for the same register occur together, the set wins.
- stall is combinational: (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]) || (rd!=0 && pending[rd]). This blocks RAW hazards and WAW between an ALU write and an outstanding load.
- ld_ready = ld_count < DEPTH, combinational from registered state.

Decomposition:
- Shared package wb_pkg holds REG_ADDR_W=5, the X0 constant, and the wb_src enum (NONE, ALU, LD_FIFO, LD_BYPASS).
- One sub-module, wb_fifo (sync FIFO: push/pop/full/empty/count, parameterised XLEN+5 width and DEPTH). The scoreboard and arbitration live in wb_arbiter.

Test Plan:
- Reset, then single ALU result alu_rd=5, alu_data=32'h1234 -> next cycle WE3=1, A3=5, WD3=32'h1234. The following cycle WE3=0.
- Idle port with ld_valid, ld_rd=7, ld_data=32'hCAFE -> bypass: next cycle WE3=1, A3=7; ld_count stays 0.
- alu_valid held high for 6 cycles while 4 load responses arrive -> ld_count reaches 4 and ld_ready=0. After the ALU stops, 4 consecutive WE3 cycles occur in arrival order, then ld_count=0.
- ld_issue rd=9, then chk_rs1=9 -> stall=1 until the cycle after the load's WE3 cycle, then stall=0. chk_rs1=0 with pending[0] never stalls.
- ALU and load results with rd=0 -> WE3 never asserts; ld_count is unchanged.
- rst asserted with 3 entries buffered and pending[9]=1 -> next cycle ld_count=0, WE3=0, stall=0, ld_ready=1.
